// File: rtl/ram_pkg.sv
// Shared constants for the 16x8 RAM board: bus widths, FSM state encoding, button bit indices.
package ram_pkg;

  localparam int unsigned DEF_ADDR_W = 4;
  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned WAIT_W     = 2;

  localparam int unsigned BTN_WR = 0;
  localparam int unsigned BTN_RD = 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WRITE   = 3'd1,
    S_RD_WAIT = 3'd2,
    S_RD_CAP  = 3'd3,
    S_ADV     = 3'd4
  } state_t;

endpackage

// File: rtl/ram_btn_ctrl_tick_gen.sv
// Free-running divider: one-clk db_tick pulse during the cycle the counter sits at TICK_DIV-1.
module tick_gen #(
  parameter int unsigned TICK_DIV = 250000
) (
  input  logic clk,
  input  logic clr,
  output logic o_tick
);

  localparam int unsigned CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  logic [CNT_W-1:0] r_cnt;
  logic             r_tick;

  // Tick is registered one count early so it lines up with the terminal count.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      if (r_cnt == CNT_W'(TICK_DIV - 1)) r_cnt <= '0;
      else                                r_cnt <= r_cnt + CNT_W'(1);
      r_tick <= (r_cnt == CNT_W'(TICK_DIV - 2));
    end
  end

  assign o_tick = r_tick;

endmodule

// File: rtl/ram_btn_ctrl.sv
// Button sequencer: edge-detects debounced WRITE/READ buttons and writes switch data to,
// or reads back from, the RAM at an auto-advancing pointer.
module ram_btn_ctrl
  import ram_pkg::*;
#(
  parameter int unsigned TICK_DIV = 250000,
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned RD_LAT   = 1
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [1:0]        i_btn_db,
  input  logic [DATA_W-1:0] i_sw_data,
  input  logic [DATA_W-1:0] i_ram_dout,
  output logic              o_db_tick,
  output logic              o_ram_we,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [DATA_W-1:0] o_ram_din,
  output logic [ADDR_W-1:0] o_disp_addr,
  output logic [DATA_W-1:0] o_disp_data,
  output logic              o_busy
);

  localparam logic [WAIT_W-1:0] WAIT_INIT = (RD_LAT > 0) ? WAIT_W'(RD_LAT - 1) : '0;

  state_t              r_state, w_state_nxt;
  logic [1:0]          r_btn_prev;
  logic [1:0]          w_press;
  logic [WAIT_W-1:0]   r_wait, w_wait_nxt;
  logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
  logic [DATA_W-1:0]   r_din, w_din_nxt;
  logic [ADDR_W-1:0]   r_disp_addr, w_disp_addr_nxt;
  logic [DATA_W-1:0]   r_disp_data, w_disp_data_nxt;
  logic                r_we, r_busy;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk    (clk),
    .clr    (clr),
    .o_tick (o_db_tick)
  );

  assign w_press = i_btn_db & ~r_btn_prev;

  // State register plus all datapath registers; we/busy are decoded from the next state.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state     <= S_IDLE;
      r_btn_prev  <= 2'b00;
      r_wait      <= '0;
      r_addr      <= '0;
      r_din       <= '0;
      r_disp_addr <= '0;
      r_disp_data <= '0;
      r_we        <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_btn_prev  <= i_btn_db;
      r_wait      <= w_wait_nxt;
      r_addr      <= w_addr_nxt;
      r_din       <= w_din_nxt;
      r_disp_addr <= w_disp_addr_nxt;
      r_disp_data <= w_disp_data_nxt;
      r_we        <= (w_state_nxt == S_WRITE);
      r_busy      <= (w_state_nxt != S_IDLE);
    end
  end

  // Next-state logic; presses are only consumed in IDLE, WRITE wins a simultaneous press.
  always_comb begin
    w_state_nxt     = r_state;
    w_wait_nxt      = r_wait;
    w_addr_nxt      = r_addr;
    w_din_nxt       = r_din;
    w_disp_addr_nxt = r_disp_addr;
    w_disp_data_nxt = r_disp_data;
    case (r_state)
      S_IDLE: begin
        if (w_press[BTN_WR]) begin
          w_state_nxt = S_WRITE;
          w_din_nxt   = i_sw_data;
        end else if (w_press[BTN_RD]) begin
          w_state_nxt = (RD_LAT == 0) ? S_RD_CAP : S_RD_WAIT;
          w_wait_nxt  = WAIT_INIT;
        end
      end
      S_WRITE: begin
        w_disp_addr_nxt = r_addr;
        w_disp_data_nxt = r_din;
        w_state_nxt     = S_ADV;
      end
      S_RD_WAIT: begin
        if (r_wait == '0) w_state_nxt = S_RD_CAP;
        else              w_wait_nxt  = r_wait - WAIT_W'(1);
      end
      S_RD_CAP: begin
        w_disp_addr_nxt = r_addr;
        w_disp_data_nxt = i_ram_dout;
        w_state_nxt     = S_ADV;
      end
      S_ADV: begin
        w_addr_nxt  = r_addr + ADDR_W'(1);
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign o_ram_we    = r_we;
  assign o_ram_addr  = r_addr;
  assign o_ram_din   = r_din;
  assign o_disp_addr = r_disp_addr;
  assign o_disp_data = r_disp_data;
  assign o_busy      = r_busy;

endmodule

// File: tb/tb_ram_btn_ctrl.sv
// Self-checking bench for ram_btn_ctrl: behavioural RAM plus an address/contents model.
module tb_ram_btn_ctrl;

  localparam int unsigned TICK_DIV = 4;
  localparam int unsigned ADDR_W   = 4;
  localparam int unsigned DATA_W   = 8;
  localparam int unsigned RD_LAT   = 1;
  localparam int unsigned DEPTH    = 16;

  logic              clk = 1'b0;
  logic              clr = 1'b1;
  logic [1:0]        btn_db = 2'b00;
  logic [DATA_W-1:0] sw_data = '0;
  logic [DATA_W-1:0] ram_dout;
  logic              db_tick, ram_we, busy;
  logic [ADDR_W-1:0] ram_addr, disp_addr;
  logic [DATA_W-1:0] ram_din, disp_data;

  logic [DATA_W-1:0] ram_mem [DEPTH];
  logic [DATA_W-1:0] ram_q;

  logic [DATA_W-1:0] model_mem [DEPTH];
  bit                model_valid [DEPTH];
  int unsigned       exp_addr;
  int                n_assert = 0;
  int                n_fail   = 0;

  ram_btn_ctrl #(
    .TICK_DIV(TICK_DIV), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)
  ) dut (
    .clk         (clk),
    .clr         (clr),
    .i_btn_db    (btn_db),
    .i_sw_data   (sw_data),
    .i_ram_dout  (ram_dout),
    .o_db_tick   (db_tick),
    .o_ram_we    (ram_we),
    .o_ram_addr  (ram_addr),
    .o_ram_din   (ram_din),
    .o_disp_addr (disp_addr),
    .o_disp_data (disp_data),
    .o_busy      (busy)
  );

  always #5 clk = ~clk;

  // Synchronous RAM with one cycle of read latency.
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_addr] <= ram_din;
    ram_q <= ram_mem[ram_addr];
  end
  assign ram_dout = ram_q;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [1:0] btn, input logic [DATA_W-1:0] d);
    sw_data = d;
    btn_db  = btn;
    step();
    btn_db = 2'b00;
    chk("wr_we", 32'(ram_we), 32'd1);
    chk("wr_addr", 32'(ram_addr), exp_addr);
    chk("wr_din", 32'(ram_din), 32'(d));
    chk("wr_busy", 32'(busy), 32'd1);
    step();
    chk("wr_we_once", 32'(ram_we), 32'd0);
    chk("wr_disp_addr", 32'(disp_addr), exp_addr);
    chk("wr_disp_data", 32'(disp_data), 32'(d));
    step();
    model_mem[exp_addr]   = d;
    model_valid[exp_addr] = 1'b1;
    exp_addr = (exp_addr + 1) % DEPTH;
    chk("wr_adv_addr", 32'(ram_addr), exp_addr);
    chk("wr_idle", 32'(busy), 32'd0);
  endtask

  task automatic do_read();
    btn_db = 2'b10;
    step();
    btn_db = 2'b00;
    chk("rd_busy", 32'(busy), 32'd1);
    chk("rd_no_we", 32'(ram_we), 32'd0);
    repeat (RD_LAT) step();
    step();
    chk("rd_disp_addr", 32'(disp_addr), exp_addr);
    if (model_valid[exp_addr]) chk("rd_disp_data", 32'(disp_data), 32'(model_mem[exp_addr]));
    step();
    exp_addr = (exp_addr + 1) % DEPTH;
    chk("rd_adv_addr", 32'(ram_addr), exp_addr);
    chk("rd_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    int we_seen;
    int unsigned abort_addr;
    for (int i = 0; i < int'(DEPTH); i++) model_valid[i] = 1'b0;
    exp_addr = 0;

    // Reset values while clr is held.
    #1;
    chk("rst_tick", 32'(db_tick), 32'd0);
    chk("rst_we", 32'(ram_we), 32'd0);
    chk("rst_addr", 32'(ram_addr), 32'd0);
    chk("rst_din", 32'(ram_din), 32'd0);
    chk("rst_disp", {20'd0, disp_addr, disp_data}, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    step();
    step();
    clr = 1'b0;

    // Divider: tick on cycles 3, 7, 11 after release.
    for (int k = 1; k <= 12; k++) begin
      step();
      chk($sformatf("tick_c%0d", k), 32'(db_tick), 32'((k % 4) == 3));
      chk("idle_outs", {26'd0, ram_we, busy, ram_addr}, 32'd0);
    end

    do_write(2'b01, 8'hA5);

    for (int i = 0; i < 16; i++) do_write(2'b01, 8'(i));
    chk("wrap_back", 32'(ram_addr), 32'd1);
    for (int i = 0; i < 16; i++) do_read();

    // Simultaneous press: write only.
    do_write(2'b11, 8'h3C);
    repeat (3) step();
    chk("both_no_read", 32'(ram_addr), exp_addr);

    // Held read button plus a write press while busy.
    btn_db = 2'b10;
    step();
    chk("hold_busy", 32'(busy), 32'd1);
    btn_db = 2'b11;
    step();
    btn_db = 2'b10;
    we_seen = 0;
    for (int c = 3; c <= 20; c++) begin
      step();
      if (ram_we) we_seen++;
    end
    chk("hold_no_we", 32'(we_seen), 32'd0);
    chk("hold_disp_addr", 32'(disp_addr), exp_addr);
    if (model_valid[exp_addr]) chk("hold_disp_data", 32'(disp_data), 32'(model_mem[exp_addr]));
    exp_addr = (exp_addr + 1) % DEPTH;
    chk("hold_one_adv", 32'(ram_addr), exp_addr);
    btn_db = 2'b00;
    repeat (3) step();
    chk("hold_idle", 32'(busy), 32'd0);
    chk("hold_addr_stable", 32'(ram_addr), exp_addr);

    // Reset in the middle of a write.
    abort_addr = exp_addr;
    sw_data = 8'h5A;
    btn_db  = 2'b01;
    step();
    btn_db = 2'b00;
    chk("clr_pre_we", 32'(ram_we), 32'd1);
    #2 clr = 1'b1;
    #1;
    chk("clr_we_async", 32'(ram_we), 32'd0);
    chk("clr_addr", 32'(ram_addr), 32'd0);
    chk("clr_busy", 32'(busy), 32'd0);
    chk("clr_disp", {20'd0, disp_addr, disp_data}, 32'd0);
    chk("clr_din", 32'(ram_din), 32'd0);
    model_valid[abort_addr] = 1'b0;
    exp_addr = 0;
    step();
    clr = 1'b0;
    repeat (4) step();
    chk("post_clr_busy", 32'(busy), 32'd0);
    chk("post_clr_we", 32'(ram_we), 32'd0);
    chk("post_clr_addr", 32'(ram_addr), 32'd0);

    // Random mix of writes, reads and simultaneous presses.
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 2))
        0:       do_write(2'b01, 8'($urandom));
        1:       do_read();
        default: do_write(2'b11, 8'($urandom));
      endcase
      repeat ($urandom_range(0, 2)) step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
